oled_spi_byte_tx: RTL and testbench

- SPI byte serializer that sits directly downstream of the OLED init and example sequencers. It is the shared transmit stage both sequencers drive through the top-level output mux.
- Accepts one byte plus a D/C flag under a level SEND / FIN handshake.
- Shifts the byte MSB-first to the SSD1306 in SPI mode 3 (SCLK idles high, slave samples on the rising edge), framing it with CS.
- Data-path timing and chip-select framing live in this block only; the sequencers deal only in bytes.

---
 rtl/oled_pkg.sv | 27 ++
 rtl/oled_spi_byte_tx.sv | 135 +++++++++++++
 tb/tb_oled_spi_byte_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
// Shared definitions for the OLED sequencers and the SPI byte transmitter.
package oled_pkg;

  // Transmitter states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int   SPI_BITS  = 8;
  localparam logic SCLK_IDLE = 1'b1;

  // Default SCLK half-period in system clocks; sequencers size their delay
  // budgets from this so they agree with the transmitter on frame length.
  localparam int OLED_CLK_DIV = 16;

  // Cycles from the accepting edge to FIN rising: CS setup, 16 SCLK
  // half-periods and CS hold.
  function automatic int frame_cycles(input int clk_div);
    return (2 * SPI_BITS + 2) * clk_div;
  endfunction

endpackage

// File: rtl/oled_spi_byte_tx.sv
// SPI mode-3 byte serializer for the SSD1306: MSB first, CS framed, with a
// level SEND / FIN handshake toward the init and example sequencers.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for SEND with FIN low; CS high, SCLK high
// SETUP | CS low, SCLK still high for one half-period (CS setup)
// LOW   | SCLK low, SDO carries the current bit
// HIGH  | SCLK high, slave has sampled SDO on the rising edge
// HOLD  | last bit done, SCLK high, CS still low (CS hold)
// DONE  | CS high, FIN high until the sequencer drops SEND
module oled_spi_byte_tx
  import oled_pkg::*;
#(
  parameter int CLK_DIV = OLED_CLK_DIV
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SEND,
  input  logic [7:0] DATA,
  input  logic       DC_IN,
  output logic       CS,
  output logic       SCLK,
  output logic       SDO,
  output logic       DC,
  output logic       BUSY,
  output logic       FIN
);

  localparam int CW = $clog2(CLK_DIV) + 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          expire;

  // Half-period timer terminal count
  assign expire = (cnt == CW'(CLK_DIV - 1));

  // Single registered FSM: timer, shifter and all outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      CS      <= 1'b1;
      SCLK    <= SCLK_IDLE;
      SDO     <= 1'b0;
      DC      <= 1'b0;
      BUSY    <= 1'b0;
      FIN     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (SEND && !FIN) begin
            shreg <= DATA;
            DC    <= DC_IN;
            CS    <= 1'b0;
            BUSY  <= 1'b1;
            state <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (expire) begin
            cnt     <= '0;
            SCLK    <= 1'b0;
            SDO     <= shreg[7];
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= '0;
            state   <= S_LOW;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_LOW: begin
          if (expire) begin
            cnt   <= '0;
            SCLK  <= 1'b1;
            state <= S_HIGH;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_HIGH: begin
          if (expire) begin
            cnt <= '0;
            if (bit_cnt == 3'(SPI_BITS - 1)) begin
              state <= S_HOLD;
            end else begin
              SCLK    <= 1'b0;
              SDO     <= shreg[7];
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              state   <= S_LOW;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_HOLD: begin
          if (expire) begin
            cnt   <= '0;
            CS    <= 1'b1;
            FIN   <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DONE: begin
          cnt <= '0;
          if (!SEND) begin
            FIN   <= 1'b0;
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_spi_byte_tx.sv
// Self-checking bench: one instance at CLK_DIV=2, one at CLK_DIV=1.
module tb_oled_spi_byte_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] send = 2'b00;
  logic [7:0] data = 8'h00;
  logic       dc_in = 1'b0;
  logic [1:0] cs, sclk, sdo, dc, busy, fin;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  oled_spi_byte_tx #(.CLK_DIV(2)) dut0 (
    .CLK(clk), .RST(rst), .SEND(send[0]), .DATA(data), .DC_IN(dc_in),
    .CS(cs[0]), .SCLK(sclk[0]), .SDO(sdo[0]), .DC(dc[0]), .BUSY(busy[0]), .FIN(fin[0])
  );

  oled_spi_byte_tx #(.CLK_DIV(1)) dut1 (
    .CLK(clk), .RST(rst), .SEND(send[1]), .DATA(data), .DC_IN(dc_in),
    .CS(cs[1]), .SCLK(sclk[1]), .SDO(sdo[1]), .DC(dc[1]), .BUSY(busy[1]), .FIN(fin[1])
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame on instance u starting at the current sample point.
  // hold: SEND dropped after the sample hold cycles past the accepting edge.
  // chg: sample index after which DATA/DC_IN are corrupted (-1 = never).
  task automatic frame(input int u, input logic [7:0] d, input logic dcv,
                       input int hold, input int chg);
    int   div    = (u == 1) ? 1 : 2;
    int   fin_k  = 18 * div;
    int   last   = ((hold > fin_k) ? hold : fin_k) + 1;
    int   fin_hi = last - 1;
    int   edges  = 0;
    logic psclk, psdo;
    logic [7:0] exp_bits[$];
    for (int b = 7; b >= 0; b--) exp_bits.push_back(d[b]);
    send[u] = 1'b1;
    data    = d;
    dc_in   = dcv;
    psclk   = sclk[u];
    psdo    = sdo[u];
    for (int k = 0; k <= last; k++) begin
      step();
      if (psclk == 1'b0 && sclk[u] == 1'b1) begin
        edges++;
        if (exp_bits.size() > 0) chk("sdo_bit", 8'(sdo[u]), exp_bits.pop_front());
        else chk("extra_sclk_edge", 8'(edges), 8'd8);
        chk("sdo_stable", 8'(sdo[u]), 8'(psdo));
      end
      if (k >= 1 && k < fin_k) chk("cs_low", 8'(cs[u]), 8'd0);
      if (k >= fin_k) chk("cs_high", 8'(cs[u]), 8'd1);
      if (k < fin_k) chk("dc_frame", 8'(dc[u]), 8'(dcv));
      if (k == fin_k || k == fin_k - 1 || k > fin_hi)
        chk("fin", 8'(fin[u]), 8'((k >= fin_k && k <= fin_hi) ? 1 : 0));
      if (k == 0 || k == fin_hi || k > fin_hi)
        chk("busy", 8'(busy[u]), 8'((k <= fin_hi) ? 1 : 0));
      if (k == 1 || k == div) chk("sclk_timing", 8'(sclk[u]), 8'((k >= div) ? 0 : 1));
      psclk = sclk[u];
      psdo  = sdo[u];
      if (k == hold) send[u] = 1'b0;
      if (k == chg) begin
        data  = 8'hFF;
        dc_in = 1'b0;
      end
    end
    chk("edge_count", 8'(edges), 8'd8);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rdc;
    int         ru, rh;

    repeat (3) step();
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      chk("rst_cs", 8'(cs[u]), 8'd1);
      chk("rst_sclk", 8'(sclk[u]), 8'd1);
      chk("rst_sdo", 8'(sdo[u]), 8'd0);
      chk("rst_dc", 8'(dc[u]), 8'd0);
      chk("rst_busy", 8'(busy[u]), 8'd0);
      chk("rst_fin", 8'(fin[u]), 8'd0);
    end

    // A5, SEND held well past FIN
    frame(0, 8'hA5, 1'b0, 40, -1);
    step();
    // 3C with DATA/DC_IN corrupted mid-frame
    frame(0, 8'h3C, 1'b1, 40, 5);
    step();
    // Back-to-back: SEND dropped one cycle after FIN, second frame at once
    frame(0, 8'hA5, 1'b0, 37, -1);
    frame(0, 8'h81, 1'b0, 37, -1);
    step();

    // Reset mid bit 3
    send[0] = 1'b1;
    data    = 8'hC3;
    for (int k = 0; k <= 12; k++) step();
    rst     = 1'b1;
    send[0] = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_cs", 8'(cs[0]), 8'd1);
    chk("midrst_sclk", 8'(sclk[0]), 8'd1);
    chk("midrst_fin", 8'(fin[0]), 8'd0);
    chk("midrst_busy", 8'(busy[0]), 8'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("post_rst_idle_sclk", 8'(sclk[0]), 8'd1);
    end
    frame(0, 8'h00, 1'b0, 40, -1);
    step();

    // SEND held for one cycle only
    frame(0, 8'h5A, 1'b1, 0, -1);
    step();

    // CLK_DIV=1
    frame(1, 8'hFF, 1'b0, 20, -1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("div1_idle_sclk", 8'(sclk[1]), 8'd1);
      chk("div1_idle_cs", 8'(cs[1]), 8'd1);
    end

    // Randomized frames
    for (int i = 0; i < 8; i++) begin
      rd  = 8'($urandom);
      rdc = 1'($urandom_range(0, 1));
      ru  = $urandom_range(0, 1);
      rh  = $urandom_range(0, 18 * ((ru == 1) ? 1 : 2) + 4);
      frame(ru, rd, rdc, rh, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : -1);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
